// File: rtl/bignum_pkg.sv
// Shared big-number constants and the divider FSM state type, used by the
// divider and the multiplier blocks.
package bignum_pkg;

   localparam int BIGNUM_WIDTH = 4096;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then compare
// and conditionally subtract the divisor, producing one quotient bit.
module div_step
   import bignum_pkg::*;
#(
   parameter int WIDTH = BIGNUM_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] wide_divisor;

   // Compare and subtract run on the full WIDTH+1 bit partial remainder.
   // Because rem_in < divisor, the value kept afterwards is always below the
   // divisor, so returning only the low WIDTH bits loses nothing.
   always_comb begin
      shifted      = {rem_in, bit_in};
      wide_divisor = {1'b0, divisor};
      q_bit        = (shifted >= wide_divisor);
      rem_out      = q_bit ? WIDTH'(shifted - wide_divisor) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/shift_sub_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes.
// Define DIVIDER_DBZ_EN to enable the one-cycle divide-by-zero fast path.
module shift_sub_divider
   import bignum_pkg::*;
#(
   parameter int WIDTH = BIGNUM_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state;
   div_state_t       state_next;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] step_rem;
   logic [CNT_W-1:0] cnt;
   logic             step_q;
   logic             zero_fast;

`ifdef DIVIDER_DBZ_EN
   logic dbz_r;
   assign zero_fast = (divisor == '0);
   assign dbz       = dbz_r && (state == DONE);
`else
   assign zero_fast = 1'b0;
   assign dbz       = 1'b0;
`endif

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in (rem_r),
      .bit_in (quo_sh[WIDTH-1]),
      .divisor(div_r),
      .rem_out(step_rem),
      .q_bit  (step_q)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = zero_fast ? DONE : RUN;
         end
         RUN: begin
            if (cnt == LAST_CNT) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // quo_sh starts as the dividend and is shifted left each step, so its MSB
   // feeds the next dividend bit while quotient bits fill in from the bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_sh <= '0;
         rem_r  <= '0;
         div_r  <= '0;
         cnt    <= '0;
`ifdef DIVIDER_DBZ_EN
         dbz_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  div_r <= divisor;
                  cnt   <= '0;
                  if (zero_fast) begin
                     quo_sh <= '1;
                     rem_r  <= dividend;
                  end else begin
                     quo_sh <= dividend;
                     rem_r  <= '0;
                  end
`ifdef DIVIDER_DBZ_EN
                  dbz_r <= zero_fast;
`endif
               end
            end
            RUN: begin
               quo_sh <= {quo_sh[WIDTH-2:0], step_q};
               rem_r  <= step_rem;
               cnt    <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign quotient  = (state == DONE) ? quo_sh : '0;
   assign remainder = (state == DONE) ? rem_r  : '0;

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4096, giving the operand and result bit width (legal range 2..4096).
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port in_valid, input, 1: dividend/divisor presented.
REQ-005 Port in_ready, output, 1: block accepts operands this cycle.
REQ-006 Port dividend, input, WIDTH: unsigned numerator.
REQ-007 Port divisor, input, WIDTH: unsigned denominator.
REQ-008 Port out_valid, output, 1: quotient/remainder valid.
REQ-009 Port out_ready, input, 1: consumer takes the result.
REQ-010 Port quotient, output, WIDTH: floor(dividend/divisor).
REQ-011 Port remainder, output, WIDTH: dividend mod divisor.
REQ-012 Port dbz, output, 1: divide-by-zero flag, valid with out_valid.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE SHALL drive in_ready=1; all other states SHALL drive in_ready=0.
REQ-015 Accept SHALL occur when in_valid && in_ready; both operands SHALL be latched and the FSM SHALL move to RUN.
REQ-016 RUN SHALL use restoring division, one quotient bit per cycle, MSB first: rem' = {rem, next dividend bit}; if rem' >= divisor then subtract and set the quotient bit to 1, else set it to 0.
REQ-017 The partial remainder SHALL be WIDTH+1 bits; no compare or subtract SHALL truncate.
REQ-018 A bit counter of $clog2(WIDTH) bits SHALL count WIDTH RUN cycles; after the last RUN cycle the FSM SHALL enter DONE.
REQ-019 Latency SHALL be exactly WIDTH+1 cycles from the accept edge to the first cycle with out_valid=1.
REQ-020 DONE SHALL hold out_valid=1 with quotient, remainder and dbz stable until out_valid && out_ready.
REQ-021 On that handshake the FSM SHALL return to IDLE; in_ready SHALL rise on the next cycle (no same-cycle re-accept).
REQ-022 quotient and remainder SHALL read 0 outside DONE.
REQ-023 in_valid asserted outside IDLE SHALL be ignored and operands SHALL NOT be sampled.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 dividend < divisor SHALL give quotient=0 and remainder=dividend; divisor=1 SHALL give quotient=dividend and remainder=0.

Reset
REQ-026 rst SHALL force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0 and counter=0 on the next edge.
REQ-027 rst during RUN or DONE SHALL abort the operation with no result delivered.
REQ-028 rst SHALL take priority over a simultaneous accept or result handshake.

Configuration
REQ-029 The macro DIVIDER_DBZ_EN SHALL select the divide-by-zero fast path.
REQ-030 With DIVIDER_DBZ_EN defined, accept with divisor=0 SHALL skip RUN and enter DONE on the next cycle (latency 1), with quotient=all ones, remainder=dividend and dbz=1.
REQ-031 Without DIVIDER_DBZ_EN, divisor=0 SHALL run the full WIDTH+1 latency and naturally yield quotient=all ones and remainder=dividend; dbz SHALL be tied to 0.

Structure
REQ-032 A shared package bignum_pkg SHALL hold the default WIDTH constant (4096) and the FSM state enum typedef div_state_t; the multiplier blocks reuse the WIDTH constant.
REQ-033 A single sub-module div_step SHALL hold the combinational shift-compare-subtract for one quotient bit.
REQ-034 Everything else SHALL stay in shift_sub_divider.

Verification
REQ-035 WIDTH=8, dividend=200, divisor=7 -> out_valid on cycle 9 after accept; quotient=28, remainder=4, dbz=0.
REQ-036 WIDTH=8, dividend=5, divisor=9 -> quotient=0, remainder=5; dividend=255, divisor=1 -> quotient=255, remainder=0.
REQ-037 WIDTH=8, divisor=0, dividend=77 -> with DIVIDER_DBZ_EN: out_valid after 1 cycle, quotient=255, remainder=77, dbz=1; without it: latency 9, same quotient and remainder, dbz=0.
REQ-038 out_ready held low 20 cycles in DONE -> outputs stable and in_ready=0 throughout; new in_valid ignored.
REQ-039 rst asserted 4 cycles into RUN -> next cycle IDLE, in_ready=1, out_valid=0; a following 100/10 operation -> quotient=10, remainder=0.
REQ-040 WIDTH=4096, random 4096-bit dividend and 2048-bit divisor, 50 vectors -> quotient*divisor+remainder == dividend and remainder < divisor; latency 4097.
